seq_stage_fetch: RTL and testbench

//  Instruction fetch stage, directly upstream of the read/decode stage.
//  - Owns the PC and issues reads to a synchronous instruction memory.
//  - Delivers registered 16-bit instructions, with a valid flag and PC tag, to the decode stage.
//  - Absorbs downstream stalls via a 1-entry skid register; supports redirect (flush) and halt.

---
 rtl/seq_stage_fetch.sv | 111 +++++++++++
 tb/tb_seq_stage_fetch.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_stage_fetch.sv
// Instruction fetch stage: owns the PC, reads a synchronous instruction memory and
// hands registered instructions to decode through a 1-entry skid. Option: FETCH_PERF_CNT_EN.
module seq_stage_fetch #(
    parameter int                      ADDRESS_SIZE  = 10,
    parameter logic [ADDRESS_SIZE-1:0] RESET_ADDRESS = '0,
    parameter logic [15:0]             NOP_INSTR     = 16'h0000
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_stall,
    input  logic                    i_flush,
    input  logic [ADDRESS_SIZE-1:0] i_jump_address,
    input  logic                    i_halt,
    output logic [ADDRESS_SIZE-1:0] o_imem_address,
    output logic                    o_imem_read,
    input  logic [15:0]             i_imem_data,
    output logic [15:0]             o_instruction,
    output logic [ADDRESS_SIZE-1:0] o_pc,
    output logic                    o_valid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]             o_fetch_count
`endif
);

    typedef enum logic {
        RUN,
        HALTED
    } state_t;

    state_t                  state;
    logic [ADDRESS_SIZE-1:0] pc;
    logic                    pending;
    logic [ADDRESS_SIZE-1:0] pend_pc;
    logic                    skid_valid;
    logic [15:0]             skid_instr;
    logic [ADDRESS_SIZE-1:0] skid_pc;

    assign o_imem_address = pc;
    assign o_imem_read    = (state == RUN) && !i_stall && !i_flush && !i_halt;

    // PC, run/halt state and tracking of the read whose data returns next cycle
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= RUN;
            pc      <= RESET_ADDRESS;
            pending <= 1'b0;
            pend_pc <= RESET_ADDRESS;
        end else begin
            pending <= o_imem_read;
            if (i_flush) begin
                state <= RUN;
                pc    <= i_jump_address;
            end else begin
                if (state == RUN && i_halt) begin
                    state <= HALTED;
                end
                if (o_imem_read) begin
                    pc      <= pc + ADDRESS_SIZE'(1);
                    pend_pc <= pc;
                end
            end
        end
    end

    // Output register; a read returning during a stall parks in the skid entry
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_valid       <= 1'b0;
            o_instruction <= NOP_INSTR;
            o_pc          <= RESET_ADDRESS;
            skid_valid    <= 1'b0;
            skid_instr    <= NOP_INSTR;
            skid_pc       <= RESET_ADDRESS;
        end else if (i_flush) begin
            o_valid       <= 1'b0;
            o_instruction <= NOP_INSTR;
            skid_valid    <= 1'b0;
        end else if (i_stall) begin
            if (pending) begin
                skid_instr <= i_imem_data;
                skid_pc    <= pend_pc;
                skid_valid <= 1'b1;
            end
        end else if (skid_valid) begin
            o_valid       <= 1'b1;
            o_instruction <= skid_instr;
            o_pc          <= skid_pc;
            skid_valid    <= 1'b0;
        end else if (pending) begin
            o_valid       <= 1'b1;
            o_instruction <= i_imem_data;
            o_pc          <= pend_pc;
        end else begin
            o_valid       <= 1'b0;
            o_instruction <= NOP_INSTR;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // Counts instructions actually accepted by decode; survives flushes, saturates
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_fetch_count <= '0;
        end else if (o_valid && !i_stall && (o_fetch_count != 32'hFFFF_FFFF)) begin
            o_fetch_count <= o_fetch_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_seq_stage_fetch.sv
// Directed bench for seq_stage_fetch with a behavioural synchronous memory mem[n]=16'h1000+n.
// Exercises the performance counter when FETCH_PERF_CNT_EN is defined.
module tb_seq_stage_fetch;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_stall = 1'b0;
    logic        i_flush = 1'b0;
    logic [9:0]  i_jump_address = '0;
    logic        i_halt = 1'b0;
    logic [9:0]  o_imem_address;
    logic        o_imem_read;
    logic [15:0] i_imem_data = '0;
    logic [15:0] o_instruction;
    logic [9:0]  o_pc;
    logic        o_valid;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] o_fetch_count;
`endif

    int compared = 0;
    int mismatched = 0;

    logic [15:0] mem [0:1023];

    seq_stage_fetch dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_stall        (i_stall),
        .i_flush        (i_flush),
        .i_jump_address (i_jump_address),
        .i_halt         (i_halt),
        .o_imem_address (o_imem_address),
        .o_imem_read    (o_imem_read),
        .i_imem_data    (i_imem_data),
        .o_instruction  (o_instruction),
        .o_pc           (o_pc),
        .o_valid        (o_valid)
`ifdef FETCH_PERF_CNT_EN
        ,
        .o_fetch_count  (o_fetch_count)
`endif
    );

    always #5 i_clk = ~i_clk;

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem[i] = 16'h1000 + 16'(i);
        end
    end

    always @(posedge i_clk) begin
        if (o_imem_read) begin
            i_imem_data <= mem[o_imem_address];
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        tick();
        tick();
        compared++;
        if ({o_valid, o_instruction, o_pc} !== {1'b0, 16'h0000, 10'h000}) begin
            mismatched++;
            $display("[TB] FAIL reset_outputs: got %h required %h", {o_valid, o_instruction, o_pc}, {1'b0, 16'h0000, 10'h000});
        end
        compared++;
        if (o_imem_address !== 10'h000) begin
            mismatched++;
            $display("[TB] FAIL reset_address: got %h required %h", o_imem_address, 10'h000);
        end
        i_rst = 1'b0;
    endtask

    task automatic test_sequential();
        tick();
        compared++;
        if (o_valid !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL seq_first_cycle_valid: got %b required 0", o_valid);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            compared++;
            if ({o_valid, o_instruction, o_pc} !== {1'b1, 16'(16'h1000 + k), 10'(k)}) begin
                mismatched++;
                $display("[TB] FAIL seq_out%0d: got %h required %h", k, {o_valid, o_instruction, o_pc}, {1'b1, 16'(16'h1000 + k), 10'(k)});
            end
        end
    endtask

    task automatic test_stall();
        i_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            compared++;
            if ({o_valid, o_instruction, o_pc} !== {1'b1, 16'h1003, 10'h003}) begin
                mismatched++;
                $display("[TB] FAIL stall_hold%0d: got %h required %h", k, {o_valid, o_instruction, o_pc}, {1'b1, 16'h1003, 10'h003});
            end
        end
        i_stall = 1'b0;
        for (int k = 4; k < 7; k++) begin
            tick();
            compared++;
            if ({o_valid, o_instruction, o_pc} !== {1'b1, 16'(16'h1000 + k), 10'(k)}) begin
                mismatched++;
                $display("[TB] FAIL stall_resume%0d: got %h required %h", k, {o_valid, o_instruction, o_pc}, {1'b1, 16'(16'h1000 + k), 10'(k)});
            end
        end
    endtask

    task automatic test_flush();
        i_stall = 1'b1;
        tick();
        compared++;
        if ({o_valid, o_instruction, o_pc} !== {1'b1, 16'h1006, 10'h006}) begin
            mismatched++;
            $display("[TB] FAIL flush_prestall: got %h required %h", {o_valid, o_instruction, o_pc}, {1'b1, 16'h1006, 10'h006});
        end
        i_flush = 1'b1;
        i_jump_address = 10'h200;
        tick();
        compared++;
        if ({o_valid, o_instruction} !== {1'b0, 16'h0000}) begin
            mismatched++;
            $display("[TB] FAIL flush_kill: got %h required %h", {o_valid, o_instruction}, {1'b0, 16'h0000});
        end
        compared++;
        if (o_imem_address !== 10'h200) begin
            mismatched++;
            $display("[TB] FAIL flush_redirect: got %h required %h", o_imem_address, 10'h200);
        end
        i_flush = 1'b0;
        i_stall = 1'b0;
        tick();
        compared++;
        if ({o_valid, o_imem_address} !== {1'b0, 10'h201}) begin
            mismatched++;
            $display("[TB] FAIL flush_gap: got %h required %h", {o_valid, o_imem_address}, {1'b0, 10'h201});
        end
        for (int k = 0; k < 2; k++) begin
            tick();
            compared++;
            if ({o_valid, o_instruction, o_pc} !== {1'b1, 16'(16'h1200 + k), 10'(10'h200 + k)}) begin
                mismatched++;
                $display("[TB] FAIL flush_target%0d: got %h required %h", k, {o_valid, o_instruction, o_pc}, {1'b1, 16'(16'h1200 + k), 10'(10'h200 + k)});
            end
        end
    endtask

    task automatic test_wrap();
        i_flush = 1'b1;
        i_jump_address = 10'h3FE;
        tick();
        i_flush = 1'b0;
        tick();
        tick();
        compared++;
        if ({o_valid, o_instruction, o_pc} !== {1'b1, 16'h13FE, 10'h3FE}) begin
            mismatched++;
            $display("[TB] FAIL wrap_3fe: got %h required %h", {o_valid, o_instruction, o_pc}, {1'b1, 16'h13FE, 10'h3FE});
        end
        compared++;
        if (o_imem_address !== 10'h000) begin
            mismatched++;
            $display("[TB] FAIL wrap_address: got %h required %h", o_imem_address, 10'h000);
        end
        tick();
        compared++;
        if ({o_valid, o_instruction, o_pc} !== {1'b1, 16'h13FF, 10'h3FF}) begin
            mismatched++;
            $display("[TB] FAIL wrap_3ff: got %h required %h", {o_valid, o_instruction, o_pc}, {1'b1, 16'h13FF, 10'h3FF});
        end
        tick();
        compared++;
        if ({o_valid, o_instruction, o_pc} !== {1'b1, 16'h1000, 10'h000}) begin
            mismatched++;
            $display("[TB] FAIL wrap_000: got %h required %h", {o_valid, o_instruction, o_pc}, {1'b1, 16'h1000, 10'h000});
        end
    endtask

    task automatic test_halt();
        i_halt = 1'b1;
        #1;
        compared++;
        if (o_imem_read !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL halt_read_blocked: got %b required 0", o_imem_read);
        end
        tick();
        i_halt = 1'b0;
        compared++;
        if ({o_valid, o_instruction, o_pc} !== {1'b1, 16'h1001, 10'h001}) begin
            mismatched++;
            $display("[TB] FAIL halt_drain: got %h required %h", {o_valid, o_instruction, o_pc}, {1'b1, 16'h1001, 10'h001});
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            compared++;
            if ({o_valid, o_instruction, o_imem_read} !== {1'b0, 16'h0000, 1'b0}) begin
                mismatched++;
                $display("[TB] FAIL halt_idle%0d: got %h required %h", k, {o_valid, o_instruction, o_imem_read}, {1'b0, 16'h0000, 1'b0});
            end
        end
        i_flush = 1'b1;
        i_jump_address = 10'h010;
        tick();
        i_flush = 1'b0;
        #1;
        compared++;
        if ({o_imem_read, o_imem_address} !== {1'b1, 10'h010}) begin
            mismatched++;
            $display("[TB] FAIL halt_resume_read: got %h required %h", {o_imem_read, o_imem_address}, {1'b1, 10'h010});
        end
        tick();
        tick();
        compared++;
        if ({o_valid, o_instruction, o_pc} !== {1'b1, 16'h1010, 10'h010}) begin
            mismatched++;
            $display("[TB] FAIL halt_resume_out: got %h required %h", {o_valid, o_instruction, o_pc}, {1'b1, 16'h1010, 10'h010});
        end
    endtask

    task automatic test_reset_mid();
        #2;
        i_rst = 1'b1;
        #1;
        compared++;
        if ({o_valid, o_instruction, o_pc, o_imem_address} !== {1'b0, 16'h0000, 10'h000, 10'h000}) begin
            mismatched++;
            $display("[TB] FAIL reset_mid: got %h required %h", {o_valid, o_instruction, o_pc, o_imem_address}, {1'b0, 16'h0000, 10'h000, 10'h000});
        end
        tick();
        i_rst = 1'b0;
    endtask

`ifdef FETCH_PERF_CNT_EN
    task automatic test_perf_count();
        compared++;
        if (o_fetch_count !== 32'd0) begin
            mismatched++;
            $display("[TB] FAIL count_reset: got %0d required 0", o_fetch_count);
        end
        tick();
        tick();
        for (int k = 0; k < 5; k++) begin
            tick();
        end
        compared++;
        if (o_fetch_count !== 32'd5) begin
            mismatched++;
            $display("[TB] FAIL count_accepted: got %0d required 5", o_fetch_count);
        end
        i_stall = 1'b1;
        tick();
        tick();
        compared++;
        if (o_fetch_count !== 32'd5) begin
            mismatched++;
            $display("[TB] FAIL count_stalled: got %0d required 5", o_fetch_count);
        end
        i_stall = 1'b0;
        #2;
        i_rst = 1'b1;
        #1;
        compared++;
        if (o_fetch_count !== 32'd0) begin
            mismatched++;
            $display("[TB] FAIL count_async_reset: got %0d required 0", o_fetch_count);
        end
        tick();
        i_rst = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_flush();
        test_wrap();
        test_halt();
        test_reset_mid();
`ifdef FETCH_PERF_CNT_EN
        test_perf_count();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
